// File: rtl/icache_defs.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
package icache_defs;
    localparam int ADDR_WIDTH      = 10;
    localparam int TAG_W           = 3;
    localparam int INDEX_W         = 3;
    localparam int OFFSET_W        = 4;
    localparam int BLOCK_BITS      = 128;
    localparam int NUM_BLOCKS      = 1 << INDEX_W;
    localparam int WORDS_PER_BLOCK = BLOCK_BITS / 32;
    localparam int BLOCK_ADDR_W    = ADDR_WIDTH - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;
endpackage

// File: rtl/icache_word_select.sv
// Picks one little-endian 32-bit instruction out of a 128-bit cache line.
module icache_word_select
    import icache_defs::*;
(
    input  logic [BLOCK_BITS-1:0] block,
    input  logic [1:0]            sel,
    output logic [31:0]           instruction
);
    logic [31:0] words [WORDS_PER_BLOCK];

    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
            assign words[gi] = block[32*gi +: 32];
        end
    endgenerate

    assign instruction = words[sel];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-block
// refill from instruction memory on a miss with a busywait stall to the CPU.
module icache_direct
    import icache_defs::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    output logic [31:0]             instruction,
    output logic                    busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0]   mem_readdata,
    input  logic                    mem_busywait
);
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         word;
    logic               hit;
    logic               unused_addr_bits;

    logic [NUM_BLOCKS-1:0] valid_reg;
    logic [TAG_W-1:0]      tag_reg  [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] data_reg [NUM_BLOCKS];

    state_t state_reg, state_next;
    // High during the first MEM_READ cycle, before memory has seen mem_read.
    logic   first_read_reg;

    assign tag              = address[ADDR_WIDTH-1 -: TAG_W];
    assign index            = address[OFFSET_W +: INDEX_W];
    assign word             = address[3:2];
    assign unused_addr_bits = ^address[1:0];
    assign mem_address      = address[ADDR_WIDTH-1:OFFSET_W];
    assign hit              = valid_reg[index] && (tag_reg[index] == tag);

    icache_word_select u_word_select (
        .block       (data_reg[index]),
        .sel         (word),
        .instruction (instruction)
    );

    always_comb begin
        state_next = state_reg;
        busywait   = 1'b0;
        mem_read   = 1'b0;
        case (state_reg)
            IDLE: begin
                busywait = !hit;
                if (!hit) state_next = MEM_READ;
            end
            MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!first_read_reg && !mem_busywait) state_next = UPDATE;
            end
            UPDATE: begin
                busywait   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            busywait = 1'b0;
            mem_read = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            first_read_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            first_read_reg <= (state_reg != MEM_READ);
            if (state_reg == UPDATE) valid_reg[index] <= 1'b1;
        end
    end

    // Tags and data are never cleared; the valid bits alone gate their use.
    always_ff @(posedge clock) begin
        if (!reset && state_reg == UPDATE) begin
            data_reg[index] <= mem_readdata;
            tag_reg[index]  <= tag;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct with a behavioural memory and cache model.
`timescale 1ns/1ps
module tb_icache_direct;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   address = 10'h000;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    icache_direct dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // Instruction memory model: byte array, request on rising mem_read, fixed or random latency.
    logic [7:0] mem_bytes [1024];
    int         fixed_lat  = 40;
    bit         rand_lat   = 1'b0;
    int         miss_count = 0;
    logic       prev_rd    = 1'b0;
    int         lat_cnt    = 0;
    logic [5:0] req_addr_q = '0;

    function automatic logic [127:0] block_of(input logic [5:0] ba);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = mem_bytes[{ba, 4'b0000} + k];
        return b;
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        int base;
        base = {a[9:2], 2'b00};
        return {mem_bytes[base+3], mem_bytes[base+2], mem_bytes[base+1], mem_bytes[base]};
    endfunction

    always @(posedge clock) begin
        int l;
        prev_rd <= mem_read;
        if (mem_read && !prev_rd) begin
            l = rand_lat ? int'($urandom_range(1, 50)) : fixed_lat;
            miss_count   = miss_count + 1;
            lat_cnt      <= l;
            req_addr_q   <= mem_address;
            mem_busywait <= 1'b1;
        end else if (mem_busywait) begin
            if (lat_cnt <= 1) begin
                mem_busywait <= 1'b0;
                mem_readdata <= block_of(req_addr_q);
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Reference cache contents: which tag each line holds, if any.
    bit         model_valid [8];
    logic [2:0] model_tag   [8];

    task automatic model_access(input logic [9:0] a, output bit exp_hit);
        exp_hit = model_valid[a[6:4]] && (model_tag[a[6:4]] == a[9:7]);
        model_valid[a[6:4]] = 1'b1;
        model_tag[a[6:4]]   = a[9:7];
    endtask

    task automatic do_reset(input logic [9:0] a);
        @(negedge clock);
        reset   = 1'b1;
        address = a;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] a, output logic [31:0] ins, output int stall,
                         output int nreq, output logic [5:0] req_addr, output bit timeout);
        int  m0;
        bit  seen;
        m0 = miss_count;
        @(negedge clock);
        address = a;
        #1;
        stall = 0; seen = 1'b0; req_addr = 6'h00;
        while (busywait && stall < 300) begin
            if (mem_read && !seen) begin
                req_addr = mem_address;
                seen     = 1'b1;
            end
            @(negedge clock);
            #1;
            stall++;
        end
        timeout = busywait;
        ins     = instruction;
        nreq    = miss_count - m0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset   = 1'b1;
        address = 10'h000;
        @(negedge clock); #1;
        tests_run++;
        if (busywait !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busywait got=%b exp=0", busywait);
        end
        tests_run++;
        if (mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_read got=%b exp=0", mem_read);
        end
        $display("[TB] reset: busywait=%b mem_read=%b", busywait, mem_read);
        do_reset(10'h000);
    endtask

    task automatic test_first_miss();
        logic [31:0] ins; int stall, nreq; logic [5:0] ra; bit to, eh;
        logic [127:0] pat;
        pat = 128'h0000000C_0000000B_0000000A_00000009;
        for (int k = 0; k < 16; k++) mem_bytes[k] = pat[8*k +: 8];
        fixed_lat = 40; rand_lat = 1'b0;
        fetch(10'h000, ins, stall, nreq, ra, to);
        model_access(10'h000, eh);
        $display("[TB] first_miss addr=000 ins=%h stall=%0d req=%0d mem_addr=%h", ins, stall, nreq, ra);
        tests_run++;
        if (to || stall < 40) begin
            tests_failed++;
            $display("FAIL first_miss_stall got=%0d exp>=40 timeout=%b", stall, to);
        end
        tests_run++;
        if (nreq !== 1 || ra !== 6'h00) begin
            tests_failed++;
            $display("FAIL first_miss_req got=%0d/%h exp=1/00", nreq, ra);
        end
        tests_run++;
        if (ins !== 32'h00000009 || busywait !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_miss_data got=%h bw=%b exp=00000009 bw=0", ins, busywait);
        end
    endtask

    task automatic test_hits();
        logic [31:0] ins; int stall, nreq; logic [5:0] ra; bit to, eh;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0000000A; exp_w[1] = 32'h0000000B; exp_w[2] = 32'h0000000C;
        for (int i = 0; i < 3; i++) begin
            fetch(10'(4 * (i + 1)), ins, stall, nreq, ra, to);
            model_access(10'(4 * (i + 1)), eh);
            $display("[TB] hit addr=%h ins=%h stall=%0d req=%0d", 10'(4 * (i + 1)), ins, stall, nreq);
            tests_run++;
            if (ins !== exp_w[i] || stall != 0 || nreq != 0) begin
                tests_failed++;
                $display("FAIL hit_word%0d got=%h stall=%0d req=%0d exp=%h stall=0 req=0",
                         i + 1, ins, stall, nreq, exp_w[i]);
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] ins; int stall, nreq; logic [5:0] ra; bit to, eh;
        fixed_lat = 5;
        fetch(10'h080, ins, stall, nreq, ra, to);
        model_access(10'h080, eh);
        $display("[TB] conflict addr=080 ins=%h req=%0d mem_addr=%h", ins, nreq, ra);
        tests_run++;
        if (to || nreq != 1 || ra !== 6'h08 || ins !== ref_word(10'h080)) begin
            tests_failed++;
            $display("FAIL conflict_fill got=%h req=%0d addr=%h exp=%h req=1 addr=08",
                     ins, nreq, ra, ref_word(10'h080));
        end
        fetch(10'h000, ins, stall, nreq, ra, to);
        model_access(10'h000, eh);
        $display("[TB] conflict addr=000 ins=%h req=%0d mem_addr=%h", ins, nreq, ra);
        tests_run++;
        if (to || nreq != 1 || ra !== 6'h00 || ins !== 32'h00000009) begin
            tests_failed++;
            $display("FAIL conflict_refill got=%h req=%0d addr=%h exp=00000009 req=1 addr=00",
                     ins, nreq, ra);
        end
    endtask

    task automatic test_reset_mid_miss();
        int m0, n; bit eh;
        fixed_lat = 40;
        do_reset(10'h000);
        m0 = miss_count;
        repeat (10) @(negedge clock);
        #1;
        tests_run++;
        if (mem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL midmiss_reading got=%b exp=1", mem_read);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        $display("[TB] midmiss reset: mem_read=%b busywait=%b", mem_read, busywait);
        tests_run++;
        if (mem_read !== 1'b0 || busywait !== 1'b0) begin
            tests_failed++;
            $display("FAIL midmiss_abort got=rd%b bw%b exp=rd0 bw0", mem_read, busywait);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
        #1;
        tests_run++;
        if (busywait !== 1'b1) begin
            tests_failed++;
            $display("FAIL midmiss_redetect got=%b exp=1", busywait);
        end
        m0 = miss_count; n = 0;
        while (busywait && n < 300) begin
            @(negedge clock); #1; n++;
        end
        model_access(10'h000, eh);
        $display("[TB] midmiss refetch ins=%h req=%0d", instruction, miss_count - m0);
        tests_run++;
        if (busywait !== 1'b0 || instruction !== 32'h00000009 || miss_count - m0 != 1) begin
            tests_failed++;
            $display("FAIL midmiss_refetch got=%h bw=%b req=%0d exp=00000009 bw=0 req=1",
                     instruction, busywait, miss_count - m0);
        end
    endtask

    task automatic test_last_word();
        logic [31:0] ins; int stall, nreq; logic [5:0] ra; bit to, eh;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) mem_bytes[10'h3FC + k] = w[8*k +: 8];
        fixed_lat = 3;
        fetch(10'h3FC, ins, stall, nreq, ra, to);
        model_access(10'h3FC, eh);
        $display("[TB] last_word addr=3FC ins=%h mem_addr=%h", ins, ra);
        tests_run++;
        if (to || ra !== 6'h3F || ins !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL last_word got=%h addr=%h exp=deadbeef addr=3f", ins, ra);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ins; int stall, nreq, total; logic [5:0] ra; bit to, eh;
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
        rand_lat = 1'b1;
        do_reset(10'h000);
        total = 0;
        for (int i = 0; i < 16; i++) begin
            fetch(10'(4 * i), ins, stall, nreq, ra, to);
            model_access(10'(4 * i), eh);
            total += nreq;
            $display("[TB] seq addr=%h ins=%h exp=%h req=%0d", 10'(4 * i), ins, ref_word(10'(4 * i)), nreq);
            tests_run++;
            if (to || ins !== ref_word(10'(4 * i))) begin
                tests_failed++;
                $display("FAIL seq_word addr=%h got=%h exp=%h", 10'(4 * i), ins, ref_word(10'(4 * i)));
            end
        end
        tests_run++;
        if (total != 4) begin
            tests_failed++;
            $display("FAIL seq_miss_count got=%0d exp=4", total);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins; int stall, nreq; logic [5:0] ra; bit to, eh;
        logic [9:0] a;
        rand_lat = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 10'(($urandom_range(0, 1) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2));
            fetch(a, ins, stall, nreq, ra, to);
            model_access(a, eh);
            $display("[TB] rand addr=%h ins=%h hit_exp=%0d req=%0d", a, ins, eh, nreq);
            tests_run++;
            if (to || ins !== ref_word(a) || nreq != (eh ? 0 : 1) || (eh && stall != 0)) begin
                tests_failed++;
                $display("FAIL rand_access addr=%h got=%h req=%0d stall=%0d exp=%h req=%0d",
                         a, ins, nreq, stall, ref_word(a), eh ? 0 : 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            model_valid[i] = 1'b0;
            model_tag[i]   = 3'd0;
        end
        test_reset();
        test_first_miss();
        test_hits();
        test_conflict();
        test_reset_mid_miss();
        test_last_word();
        test_sequential();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
